// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and defaults for the hazard scoreboard: result-latency classes,
// default latencies and the register-index width.
package hazard_scoreboard_pkg;

    localparam int RIDX_W       = 5;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_MUL_LAT  = 4;

    typedef enum logic [1:0] {
        LAT_ALU     = 2'b00,
        LAT_LOAD    = 2'b01,
        LAT_MUL     = 2'b10,
        LAT_MUL_ALT = 2'b11
    } lat_class_e;

    // A source operand can only hazard if it is really read and is not x0.
    function automatic logic reads_reg(input logic use_i, input logic [RIDX_W-1:0] idx_i);
        return use_i & (idx_i != {RIDX_W{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard scoreboard: decoded instruction fields in, stall and
// pending-register state out.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = 32
);
    logic              id_valid;
    logic [RIDX_W-1:0] id_rs1;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [RIDX_W-1:0] id_rd;
    logic              id_regwrite;
    logic [1:0]        id_lat_class;
    logic              flush;
    logic              stall;
    logic              pending_any;
    logic [NREG-1:0]   pending_mask;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_lat_class, flush,
        input  stall, pending_any, pending_mask
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_lat_class, flush,
        output stall, pending_any, pending_mask
    );
endinterface

// File: rtl/hazard_scoreboard_cnt_cell.sv
// One per-register countdown: loads a latency on issue, otherwise counts down to zero
// and holds there.
module hazard_cnt_cell #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] cnt_o,
    output logic          nz_o
);
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: a fresh issue overrides the decrement of the older write.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign nz_o  = (cnt_q != {CW{1'b0}});
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard stalling on RAW/WAW hazards against loads and MUL/DIV results.
// Optional HAZARD_STATS_EN adds stall_cycles_o / raw_stalls_o event counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int MUL_LAT  = DEF_MUL_LAT,
    parameter int CW       = 3
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  sb
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]         stall_cycles_o,
    output logic [31:0]         raw_stalls_o
`endif
);
    logic [CW-1:0]   cnt_s [NREG];
    logic [NREG-1:0] nz_s;
    logic [CW-1:0]   lat_s;
    logic            raw1_s;
    logic            raw2_s;
    logic            waw_s;
    logic            stall_s;
    logic            issue_s;

    assign cnt_s[0] = {CW{1'b0}};
    assign nz_s[0]  = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_cell
            hazard_cnt_cell #(.CW(CW)) u_cell (
                .clk        (clk),
                .rst        (rst),
                .load_i     (issue_s & sb.id_regwrite & (sb.id_rd == RIDX_W'(r))),
                .load_val_i (lat_s),
                .cnt_o      (cnt_s[r]),
                .nz_o       (nz_s[r])
            );
        end
    endgenerate

    // Result latency of the instruction in ID.
    always_comb begin
        lat_s = {CW{1'b0}};
        case (sb.id_lat_class)
            LAT_ALU:  lat_s = {CW{1'b0}};
            LAT_LOAD: lat_s = CW'(LOAD_LAT);
            default:  lat_s = CW'(MUL_LAT);
        endcase
    end

    // A younger write may not finish before an older, slower write to the same rd.
    assign raw1_s  = reads_reg(sb.id_use_rs1, sb.id_rs1) & nz_s[sb.id_rs1];
    assign raw2_s  = reads_reg(sb.id_use_rs2, sb.id_rs2) & nz_s[sb.id_rs2];
    assign waw_s   = sb.id_regwrite & (sb.id_rd != {RIDX_W{1'b0}}) & (cnt_s[sb.id_rd] > lat_s);
    assign stall_s = sb.id_valid & ~sb.flush & (raw1_s | raw2_s | waw_s);
    assign issue_s = sb.id_valid & ~sb.flush & ~stall_s;

    assign sb.stall        = stall_s;
    assign sb.pending_mask = nz_s;
    assign sb.pending_any  = |nz_s;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] raw_stalls_q;

    // Free-running stall statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            raw_stalls_q   <= 32'd0;
        end else begin
            if (stall_s) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall_s & (raw1_s | raw2_s)) begin
                raw_stalls_q <= raw_stalls_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign raw_stalls_o   = raw_stalls_q;
`endif
endmodule
